// File: rtl/dct8x8_stream.sv
// Streaming 8x8 2-D DCT: buffers 64 raster samples, runs separable row and column
// passes on one serial multiply-accumulate, then streams 64 rounded coefficients.
module dct8x8_stream #(
    parameter int DATA_W      = 8,
    parameter int COEF_W      = 11,
    parameter int NUM_CH      = 3,
    parameter int LEVEL_SHIFT = 1,
    parameter int FRAC_W      = 12,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last
);
    localparam int SW  = DATA_W + 1;
    localparam int CW  = FRAC_W + 1;
    localparam int RW  = SW + CW + 2;
    localparam int CLW = RW + CW + 3;
    localparam int FB  = 2 * FRAC_W;

    localparam logic signed [SW-1:0] SHIFT_C = {2'b01, {(DATA_W-1){1'b0}}};
    localparam logic signed [CLW:0]  ONE_C   = {{CLW{1'b0}}, 1'b1};
    localparam logic signed [CLW:0]  HALF_C  = {{(CLW-FB+1){1'b0}}, 1'b1, {(FB-1){1'b0}}};
    localparam logic signed [CLW:0]  MAX_C   = {{(CLW-COEF_W+2){1'b0}}, {(COEF_W-1){1'b1}}};
    localparam logic signed [CLW:0]  MIN_C   = {{(CLW-COEF_W+2){1'b1}}, {(COEF_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, ROW, COL, OUT} state_t;

    // cos(m*pi/16) in Q24, m = 0..8
    function automatic logic [31:0] cos_q24(input logic [3:0] m);
        logic [31:0] v;
        case (m)
            4'd0:    v = 32'd16777216;
            4'd1:    v = 32'd16454847;
            4'd2:    v = 32'd15500126;
            4'd3:    v = 32'd13949745;
            4'd4:    v = 32'd11863283;
            4'd5:    v = 32'd9320922;
            4'd6:    v = 32'd6420363;
            4'd7:    v = 32'd3273072;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // C(k)/2 * cos((2n+1)k*pi/16) in Q(FRAC_W); C(0)/2 equals cos(pi/4)/2
    function automatic logic signed [CW-1:0] dct_coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0]  m;
        logic [3:0]  mi;
        logic        neg;
        logic [31:0] mag;
        m = 5'({1'b0, n, 1'b1} * {2'b00, k});
        if (k == 3'd0) begin
            mi = 4'd4;  neg = 1'b0;
        end else if (m <= 5'd8) begin
            mi = m[3:0];  neg = 1'b0;
        end else if (m <= 5'd16) begin
            mi = 4'(5'd16 - m);  neg = 1'b1;
        end else if (m <= 5'd24) begin
            mi = 4'(m - 5'd16);  neg = 1'b1;
        end else begin
            mi = 4'(5'd0 - m);  neg = 1'b0;
        end
        mag = (cos_q24(mi) + (32'd1 << (24 - FRAC_W))) >> (25 - FRAC_W);
        return neg ? $signed(-CW'(mag)) : $signed(CW'(mag));
    endfunction

    state_t                  state_r;
    logic [8:0]              cnt_r;
    logic [CH_W-1:0]         ch_r;
    logic signed [CLW-1:0]   acc_r;
    logic                    out_valid_r, out_last_r;
    logic [COEF_W-1:0]       out_data_r;
    logic [5:0]              out_idx_r;
    logic [CH_W-1:0]         out_ch_r;

    logic signed [SW-1:0]    sbuf [64];
    logic signed [RW-1:0]    tbuf [64];
    logic [COEF_W-1:0]       obuf [64];

    logic                    accept_s;
    logic [2:0]              a_s, b_s, t_s;
    logic signed [SW-1:0]    samp_s;
    logic signed [RW-1:0]    opnd_s;
    logic signed [CW-1:0]    coef_s;
    logic signed [RW+CW-1:0] prod_s;
    logic signed [CLW-1:0]   mac_s;
    logic signed [CLW:0]     rnd_s, quo_s;
    logic [COEF_W-1:0]       res_s;
    logic [5:0]              nxt_idx_s;

    assign in_ready  = rst_n && ((state_r == IDLE) || (state_r == LOAD));
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_ch    = out_ch_r;
    assign out_last  = out_last_r;

    // Sample path, MAC datapath and final round-half-away / saturate
    always_comb begin
        accept_s  = in_valid && in_ready;
        nxt_idx_s = out_idx_r + 6'd1;
        a_s = cnt_r[8:6];
        b_s = cnt_r[5:3];
        t_s = cnt_r[2:0];
        if (LEVEL_SHIFT != 0) begin
            samp_s = $signed({1'b0, in_data}) - SHIFT_C;
        end else begin
            samp_s = $signed({1'b0, in_data});
        end
        // row pass walks sample rows; column pass walks transpose-buffer columns
        if (state_r == COL) begin
            opnd_s = tbuf[{t_s, a_s}];
        end else begin
            opnd_s = RW'(sbuf[{a_s, t_s}]);
        end
        coef_s = dct_coef(b_s, t_s);
        prod_s = opnd_s * coef_s;
        mac_s  = acc_r + CLW'(prod_s);
        rnd_s  = {mac_s[CLW-1], mac_s} + (mac_s[CLW-1] ? (HALF_C - ONE_C) : HALF_C);
        quo_s  = rnd_s >>> FB;
        if (quo_s > MAX_C) begin
            res_s = MAX_C[COEF_W-1:0];
        end else if (quo_s < MIN_C) begin
            res_s = MIN_C[COEF_W-1:0];
        end else begin
            res_s = quo_s[COEF_W-1:0];
        end
    end

    // Sample, transpose and coefficient buffers (contents survive reset)
    always_ff @(posedge clk) begin
        if (accept_s) begin
            sbuf[cnt_r[5:0]] <= samp_s;
        end
        if ((state_r == ROW) && (t_s == 3'd7)) begin
            tbuf[{a_s, b_s}] <= mac_s[RW-1:0];
        end
        if ((state_r == COL) && (t_s == 3'd7)) begin
            obuf[{b_s, a_s}] <= res_s;
        end
    end

    // Block sequencing FSM with registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 9'd0;
            ch_r        <= '0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= 6'd0;
            out_ch_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ch_r    <= in_ch;
                        cnt_r   <= 9'd1;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        if (cnt_r[5:0] == 6'd63) begin
                            cnt_r   <= 9'd0;
                            acc_r   <= '0;
                            state_r <= ROW;
                        end else begin
                            cnt_r <= cnt_r + 9'd1;
                        end
                    end
                end
                ROW, COL: begin
                    acc_r <= (t_s == 3'd7) ? '0 : mac_s;
                    cnt_r <= cnt_r + 9'd1;
                    if (cnt_r == 9'd511) begin
                        state_r <= (state_r == ROW) ? COL : OUT;
                    end
                end
                OUT: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= obuf[0];
                        out_idx_r   <= 6'd0;
                        out_last_r  <= 1'b0;
                        out_ch_r    <= ch_r;
                    end else if (out_ready) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_data_r  <= '0;
                            out_idx_r   <= 6'd0;
                            state_r     <= IDLE;
                        end else begin
                            out_idx_r  <= nxt_idx_s;
                            out_data_r <= obuf[nxt_idx_s];
                            out_last_r <= (nxt_idx_s == 6'd63);
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dct8x8_stream.md
DCT8X8_STREAM -- requirements
Module: dct8x8_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning unsigned input sample width.
REQ-002 SHALL have parameter COEF_W, default 11, meaning signed output coefficient width.
REQ-003 SHALL have parameter NUM_CH, default 3, meaning number of component channels tagged (Y/Cb/Cr); CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have parameter LEVEL_SHIFT, default 1, meaning 1 subtracts 2^(DATA_W-1) from each input sample and 0 passes the sample unchanged.
REQ-005 SHALL have parameter FRAC_W, default 12, meaning fractional bits of the cosine ROM constants.
REQ-006 SHALL have a single clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 in_valid  in  1  input sample valid.
REQ-010 in_ready  out  1  block can accept a sample.
REQ-011 in_data  in  DATA_W  pixel sample, raster order (row-major).
REQ-012 in_ch  in  CH_W  channel tag, sampled on first accept of a block.
REQ-013 out_valid  out  1  coefficient valid.
REQ-014 out_ready  in  1  downstream accepts coefficient.
REQ-015 out_data  out  COEF_W  signed DCT coefficient.
REQ-016 out_idx  out  6  coefficient index u*8+v (u = vertical frequency).
REQ-017 out_ch  out  CH_W  channel tag of the block being output.
REQ-018 out_last  out  1  high with out_idx==63.

Function
REQ-019 SHALL implement states IDLE, LOAD, ROW, COL and OUT.
REQ-020 Transitions SHALL be: IDLE->LOAD on the first accept; LOAD->ROW on the 64th accept; ROW->COL after 512 cycles; COL->OUT after 512 cycles; OUT->IDLE on the handshake of out_last.
REQ-021 A sample SHALL be accepted when in_valid && in_ready are high at a rising edge.
REQ-022 in_ready SHALL be 1 in IDLE and LOAD and 0 in ROW, COL and OUT.
REQ-023 in_ch SHALL be latched on the first accept of a block; in_ch on later accepts of the same block SHALL be ignored.
REQ-024 in_valid low during LOAD SHALL stall the sample counter without error, with no timeout.
REQ-025 ROW SHALL compute, for each row, 8 1-D DCT outputs using one multiply-accumulate per cycle (8 cycles per output) and store them in the transpose buffer.
REQ-026 COL SHALL apply the same 1-D DCT down each column of the transpose buffer.
REQ-027 The scale SHALL be F(u,v) = 1/4 C(u) C(v) sum f(x,y) cos((2x+1)u*pi/16) cos((2y+1)v*pi/16), with C(0) = 1/sqrt2 and C(k) = 1 otherwise.
REQ-028 Intermediate results SHALL carry full precision, with no wrap, until the final result.
REQ-029 Each final result SHALL be rounded to nearest with ties away from zero, then saturated to [-2^(COEF_W-1), 2^(COEF_W-1)-1].
REQ-030 Each final result SHALL be within +/-1 of the double-precision F(u,v) rounded.
REQ-031 out_valid SHALL rise exactly 1025 cycles after the edge that accepted the 64th sample.
REQ-032 Coefficients SHALL be emitted in order out_idx 0..63, one per handshake.
REQ-033 While out_valid && !out_ready, out_data, out_idx, out_ch and out_last SHALL hold stable.
REQ-034 out_valid SHALL stay high until the handshake, with no gaps between coefficients while out_ready is high.
REQ-035 In the cycle after the out_last handshake, in_ready SHALL be 1.
REQ-036 A new block SHALL NOT be accepted in the same cycle as the out_last handshake.

Reset
REQ-037 When rst_n is low, the state SHALL be IDLE and in_ready, out_valid, out_last SHALL be 0.
REQ-038 When rst_n is low, out_data, out_idx, out_ch and all counters SHALL be 0.
REQ-039 Asserting rst_n in any state, including mid-ROW/COL/OUT, SHALL discard the partial block.
REQ-040 Transpose-buffer and sample-buffer contents need not be cleared on reset.
REQ-041 The first cycle after rst_n deasserts SHALL show in_ready=1.

Verification
REQ-042 Defaults, 64 samples of 128 -> all 64 coefficients 0, out_last on idx 63.
REQ-043 Defaults, 64 samples of 255 -> idx0 = 1016, idx1..63 = 0 (+/-1); 64 samples of 0 -> idx0 = -1024, others 0.
REQ-044 Defaults, ramp sample i = i+10 (i = 0..63), in_ch = 2 -> idx0 = -692 (+/-1), out_ch = 2 on all beats, rest matching the double-precision model within +/-1; first out_valid exactly 1025 cycles after the 64th accept.
REQ-045 out_ready toggled pseudo-randomly during OUT, in_valid with random gaps during LOAD -> identical coefficient sequence to the no-stall run, outputs stable while stalled, in_ready 0 throughout ROW/COL/OUT.
REQ-046 rst_n pulsed low during COL, then a fresh block of 255s -> outputs reset immediately, no coefficients from the aborted block appear, new block gives idx0 = 1016.
REQ-047 LEVEL_SHIFT=0, COEF_W=12, 64 samples of 255 -> idx0 = 2040.
